// File: rtl/zombie_sprite_renderer_if.sv
// Pixel-path bundle: scan position and sprite ROM port in, palette index and opacity out.
// The renderer takes the slave view; the video timing / ROM / palette side takes the master view.
interface zombie_sprite_renderer_if #(
  parameter int ADDR_W = 13
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic [3:0]        palette_index;
  logic              pixel_opaque;

  modport master (
    output DrawX, DrawY, rom_data,
    input  rom_addr, palette_index, pixel_opaque
  );

  modport slave (
    input  DrawX, DrawY, rom_data,
    output rom_addr, palette_index, pixel_opaque
  );
endinterface

// File: rtl/zombie_sprite_renderer.sv
// Per-pixel sprite fetch for one zombie: bounding-box hit test, sprite ROM addressing,
// transparency keying (2-cycle latency), and the once-per-video-frame walk/death animation FSM.
module zombie_sprite_renderer #(
  parameter int SPR_W           = 32,
  parameter int SPR_H           = 32,
  parameter int WALK_FRAMES     = 4,
  parameter int DIE_FRAMES      = 4,
  parameter int TICKS_PER_STEP  = 8,
  parameter int ADDR_W          = 13,
  parameter int TRANSPARENT_IDX = 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_start,
  input  logic                     zombie_active,
  input  logic                     zombie_kill,
  input  logic [9:0]               zombie_x,
  input  logic [9:0]               zombie_y,
  zombie_sprite_renderer_if.slave  pix,
  output logic [2:0]               anim_frame,
  output logic                     death_done
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_STEP - 1);
  localparam logic [2:0]    WALK_LAST = 3'(WALK_FRAMES - 1);
  localparam logic [2:0]    DIE_FIRST = 3'(WALK_FRAMES);
  localparam logic [2:0]    DIE_LAST  = 3'(WALK_FRAMES + DIE_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DYING, S_DEAD} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [2:0]        frame_q, frame_d;
  logic              done_q, done_d;
  logic [9:0]        x_q, y_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              hit_d1_q;
  logic [3:0]        palette_q;
  logic              opaque_q;

  // ---------------- animation FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    if (frame_start) begin
      unique case (state_q)
        S_IDLE: begin
          tick_d  = '0;
          frame_d = '0;
          if (zombie_active) state_d = S_WALK;
        end
        S_WALK: begin
          if (!zombie_active) begin
            state_d = S_IDLE;
            tick_d  = '0;
            frame_d = '0;
          end else if (zombie_kill) begin
            state_d = S_DYING;
            tick_d  = '0;
            frame_d = DIE_FIRST;
          end else if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            frame_d = (frame_q == WALK_LAST) ? 3'd0 : frame_q + 3'd1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DYING: begin
          if (!zombie_active) begin
            state_d = S_IDLE;
            tick_d  = '0;
            frame_d = '0;
          end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (frame_q == DIE_LAST) begin
              state_d = S_DEAD;
              done_d  = 1'b1;
            end else begin
              frame_d = frame_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DEAD: begin
          if (!zombie_active) begin
            state_d = S_IDLE;
            tick_d  = '0;
            frame_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- pixel pipeline ----------------
  // Box compares run at 11 bits so a sprite hanging off the right/bottom edge clips instead of wrapping.
  logic [10:0]       dx_w, dy_w, x_w, y_w;
  logic              drawable, hit;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] addr;

  assign dx_w     = {1'b0, pix.DrawX};
  assign dy_w     = {1'b0, pix.DrawY};
  assign x_w      = {1'b0, x_q};
  assign y_w      = {1'b0, y_q};
  assign drawable = (state_q == S_WALK) || (state_q == S_DYING);
  assign hit      = drawable
                    && (dx_w >= x_w) && (dx_w < x_w + 11'(SPR_W))
                    && (dy_w >= y_w) && (dy_w < y_w + 11'(SPR_H));
  // Sprite dimensions are powers of two, so frame/row/col concatenate into the linear ROM address.
  assign col      = pix.DrawX[CW-1:0] - x_q[CW-1:0];
  assign row      = pix.DrawY[RW-1:0] - y_q[RW-1:0];
  assign addr     = ADDR_W'({frame_q, row, col});

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      x_q        <= '0;
      y_q        <= '0;
      rom_addr_q <= '0;
      hit_d1_q   <= 1'b0;
      palette_q  <= '0;
      opaque_q   <= 1'b0;
    end else begin
      if (frame_start) begin
        x_q <= zombie_x;
        y_q <= zombie_y;
      end
      rom_addr_q <= hit ? addr : '0;
      hit_d1_q   <= hit;
      palette_q  <= hit_d1_q ? pix.rom_data : 4'd0;
      opaque_q   <= hit_d1_q && (pix.rom_data != 4'(TRANSPARENT_IDX));
    end
  end

  assign pix.rom_addr      = rom_addr_q;
  assign pix.palette_index = palette_q;
  assign pix.pixel_opaque  = opaque_q;
  assign anim_frame        = frame_q;
  assign death_done        = done_q;

endmodule
